// File: rtl/ex_sched_pkg.sv
// ex_sched_pkg: shared types and latency helpers for the
// execute-stage scheduler (unit classes, reservation entries).
package ex_sched_pkg;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_MUL  = 2'd1,
    CLS_DIV  = 2'd2,
    CLS_FDIV = 2'd3
  } unit_class_e;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        typ;
    unit_class_e unit;
  } res_entry_t;

  function automatic int lat_of(
    input unit_class_e c,
    input int          ml,
    input int          dl,
    input int          fl
  );
    case (c)
      CLS_MUL:  return ml;
      CLS_DIV:  return dl;
      CLS_FDIV: return fl;
      default:  return 1;
    endcase
  endfunction

  function automatic int max_lat(
    input int ml,
    input int dl,
    input int fl
  );
    int m;
    m = 1;
    if (ml > m) m = ml;
    if (dl > m) m = dl;
    if (fl > m) m = fl;
    return m;
  endfunction

endpackage

// File: rtl/ex_unit_sched_if.sv
// ex_unit_sched_if: decode-to-scheduler issue bundle plus unit
// start pulses and writeback outputs. master=decode, slave=sched.
interface ex_unit_sched_if;
  logic       issue_valid_dec;
  logic [1:0] issue_class_dec;
  logic [4:0] rd_dec;
  logic       reg_type_dec;
  logic [4:0] rs1_dec;
  logic [4:0] rs2_dec;
  logic [4:0] rs3_dec;
  logic [2:0] src_used_dec;
  logic [2:0] src_type_dec;
  logic       flush_ex;
  logic       stall_dec;
  logic       mul_start_ex;
  logic       div_start_ex;
  logic       fdiv_start_ex;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       wb_type;
  logic [1:0] wb_unit;

  modport master (
    output issue_valid_dec, issue_class_dec, rd_dec,
    output reg_type_dec, rs1_dec, rs2_dec, rs3_dec,
    output src_used_dec, src_type_dec, flush_ex,
    input  stall_dec, mul_start_ex, div_start_ex,
    input  fdiv_start_ex, wb_valid, wb_rd, wb_type, wb_unit
  );

  modport slave (
    input  issue_valid_dec, issue_class_dec, rd_dec,
    input  reg_type_dec, rs1_dec, rs2_dec, rs3_dec,
    input  src_used_dec, src_type_dec, flush_ex,
    output stall_dec, mul_start_ex, div_start_ex,
    output fdiv_start_ex, wb_valid, wb_rd, wb_type, wb_unit
  );
endinterface

// File: rtl/ex_wb_resv.sv
// ex_wb_resv: writeback reservation shift register. Shifts down
// each cycle; ins_* writes the shifted table, qry_* reads current.
module ex_wb_resv
  import ex_sched_pkg::*;
#(
  parameter int DEPTH = 34,
  parameter int IW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ins_en,
  input  logic [IW-1:0] ins_idx,
  input  res_entry_t    ins_entry,
  input  logic [IW-1:0] qry_idx,
  output logic          qry_busy,
  output res_entry_t    head
);

  res_entry_t slot_q [DEPTH];
  res_entry_t shf    [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++)
      shf[i] = slot_q[i+1];
    shf[DEPTH-1] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        slot_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ins_en && ins_idx == IW'(i))
          slot_q[i] <= ins_entry;
        else
          slot_q[i] <= shf[i];
      end
    end
  end

  // Indices at or beyond DEPTH are never occupied.
  always_comb begin
    qry_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (qry_idx == IW'(i) && slot_q[i].valid)
        qry_busy = 1'b1;
  end

  assign head = slot_q[0];

endmodule

// File: rtl/ex_unit_sched.sv
// ex_unit_sched: execute issue/writeback scheduler.
// Ports: clk, reset (sync, active-high), bus (slave modport).
module ex_unit_sched
  import ex_sched_pkg::*;
#(
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 34,
  parameter int FDIV_LAT = 28
) (
  input logic            clk,
  input logic            reset,
  ex_unit_sched_if.slave bus
);

  localparam int MAXLAT =
    max_lat(MUL_LAT, DIV_LAT, FDIV_LAT);
  localparam int IW = $clog2(MAXLAT + 1);

  unit_class_e   cls;
  logic [IW-1:0] lat;
  res_entry_t    head;
  res_entry_t    new_ent;
  logic          port_hz;
  logic [31:0]   pend_int;
  logic [31:0]   pend_fp;
  logic          div_busy;
  logic          fdiv_busy;
  logic [4:0]    rs [3];
  logic [2:0]    src_pend;
  logic [2:0]    src_byp;
  logic          raw_hz;
  logic          waw_hz;
  logic          str_hz;
  logic          hazard;
  logic          live;
  logic          accept;
  logic          div_wb;
  logic          fdiv_wb;
  logic          mul_go;
  logic          div_go;
  logic          fdiv_go;
  logic [31:0]   set_int;
  logic [31:0]   set_fp;
  logic [31:0]   clr_int;
  logic [31:0]   clr_fp;

  assign cls = unit_class_e'(bus.issue_class_dec);
  assign lat = IW'(lat_of(cls, MUL_LAT,
                          DIV_LAT, FDIV_LAT));

  assign new_ent = '{valid: 1'b1,
                     rd:    bus.rd_dec,
                     typ:   bus.reg_type_dec,
                     unit:  cls};

  ex_wb_resv #(
    .DEPTH (MAXLAT),
    .IW    (IW)
  ) u_resv (
    .clk       (clk),
    .reset     (reset),
    .ins_en    (accept),
    .ins_idx   (lat - IW'(1)),
    .ins_entry (new_ent),
    .qry_idx   (lat),
    .qry_busy  (port_hz),
    .head      (head)
  );

  assign rs[0] = bus.rs1_dec;
  assign rs[1] = bus.rs2_dec;
  assign rs[2] = bus.rs3_dec;

  // A source retiring in slot 0 this cycle is forwarded.
  always_comb begin
    raw_hz   = 1'b0;
    src_pend = '0;
    src_byp  = '0;
    for (int k = 0; k < 3; k++) begin
      src_pend[k] = bus.src_type_dec[k] ?
                    pend_fp[rs[k]] : pend_int[rs[k]];
      src_byp[k]  = head.valid &&
                    head.rd == rs[k] &&
                    head.typ == bus.src_type_dec[k];
      if (bus.src_used_dec[k] && src_pend[k] &&
          !src_byp[k])
        raw_hz = 1'b1;
    end
  end

  assign waw_hz = bus.reg_type_dec ?
                  pend_fp[bus.rd_dec] :
                  pend_int[bus.rd_dec];

  assign div_wb  = head.valid && head.unit == CLS_DIV;
  assign fdiv_wb = head.valid && head.unit == CLS_FDIV;

  // The busy unit frees up in its own writeback cycle.
  assign str_hz =
    (cls == CLS_DIV  && div_busy  && !div_wb) ||
    (cls == CLS_FDIV && fdiv_busy && !fdiv_wb);

  assign hazard = raw_hz | waw_hz | str_hz | port_hz;
  assign live   = bus.issue_valid_dec & ~bus.flush_ex &
                  ~reset;
  assign accept = live & ~hazard;

  always_comb begin
    mul_go  = 1'b0;
    div_go  = 1'b0;
    fdiv_go = 1'b0;
    if (accept) begin
      unique case (cls)
        CLS_MUL:  mul_go  = 1'b1;
        CLS_DIV:  div_go  = 1'b1;
        CLS_FDIV: fdiv_go = 1'b1;
        default:  ;
      endcase
    end
  end

  // int x0 is never marked pending.
  always_comb begin
    set_int = '0;
    set_fp  = '0;
    clr_int = '0;
    clr_fp  = '0;
    if (accept && cls != CLS_ALU) begin
      if (bus.reg_type_dec)
        set_fp[bus.rd_dec] = 1'b1;
      else if (bus.rd_dec != 5'd0)
        set_int[bus.rd_dec] = 1'b1;
    end
    if (head.valid) begin
      if (head.typ)
        clr_fp[head.rd] = 1'b1;
      else
        clr_int[head.rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_int  <= '0;
      pend_fp   <= '0;
      div_busy  <= 1'b0;
      fdiv_busy <= 1'b0;
    end else begin
      pend_int  <= (pend_int & ~clr_int) | set_int;
      pend_fp   <= (pend_fp & ~clr_fp) | set_fp;
      div_busy  <= (div_busy & ~div_wb) | div_go;
      fdiv_busy <= (fdiv_busy & ~fdiv_wb) | fdiv_go;
    end
  end

  assign bus.stall_dec     = live & hazard;
  assign bus.mul_start_ex  = mul_go;
  assign bus.div_start_ex  = div_go;
  assign bus.fdiv_start_ex = fdiv_go;
  assign bus.wb_valid      = head.valid;
  assign bus.wb_rd         = head.rd;
  assign bus.wb_type       = head.typ;
  assign bus.wb_unit       = head.unit;

endmodule
